sram_like_responder: RTL and testbench
======================================

SRAM_LIKE_RESPONDER -- requirements
Module: sram_like_responder

Interface
REQ-001 Parameter AW, default 16: word-index width; memory holds 2^AW 32-bit words.
REQ-002 Parameter DEPTH, default 4: maximum outstanding accepted-but-unanswered transactions (power of 2, >=2).
REQ-003 Parameter LATENCY, default 2: minimum cycles from accept to data_ok (>=1).
REQ-004 One clock; reset is synchronous and active-high, ports named clk and reset.
REQ-005 clk  input  1  clock; all state updates on posedge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 req  input  1  initiator request valid.
REQ-008 wr  input  1  1 = write, 0 = read.
REQ-009 size  input  2  access size; carried in the entry, not used for data selection.
REQ-010 addr  input  32  byte address; word index = addr[AW+1:2], other bits ignored.
REQ-011 wstrb  input  4  write byte enables.
REQ-012 wdata  input  32  write data.
REQ-013 resp_hold  input  1  test backpressure; when 1, no data_ok is issued that cycle.
REQ-014 addr_ok  output  1  request accepted this cycle.
REQ-015 data_ok  output  1  head transaction completes this cycle.
REQ-016 rdata  output  32  read data, valid when data_ok is 1 for a read; 0 otherwise.

Function
REQ-017 addr_ok SHALL be req && (count < DEPTH), combinational, using registered count only; a same-cycle retire SHALL NOT free a slot.
REQ-018 On accept (req && addr_ok), a write SHALL immediately update the memory word bytes selected by wstrb; unselected bytes SHALL be unchanged; wstrb=0 SHALL write nothing but still produce a data_ok.
REQ-019 On accept, a read SHALL capture the memory word as it was before any write accepted in that same cycle (only one accept per cycle, so none) and store it in the entry; later writes SHALL NOT alter captured data.
REQ-020 Each entry SHALL hold wr, captured rdata, and an age counter that starts at 0 on accept, increments each cycle, and saturates at LATENCY.
REQ-021 data_ok SHALL be 1 in a cycle iff FIFO is non-empty, the head age equals LATENCY, and resp_hold is 0; the head entry SHALL then be popped at the posedge.
REQ-022 Responses SHALL be strictly in accept order, at most one per cycle; data_ok for a request accepted at posedge T SHALL occur no earlier than the cycle following posedge T+LATENCY-1 (that is, LATENCY cycles after accept).
REQ-023 rdata SHALL equal the head's captured word when data_ok && !head.wr, else 32'h0.
REQ-024 Simultaneous push and pop SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-025 When full, addr_ok SHALL be 0; a held req SHALL be accepted the cycle after a pop frees a slot.
REQ-026 Back-to-back accepts with continuous resp_hold=0 SHALL sustain one transaction per cycle throughput once the pipeline fills.

Reset
REQ-027 While reset is 1: count, read/write pointers, and all age counters SHALL be 0; addr_ok, data_ok, and rdata SHALL be 0.
REQ-028 Reset mid-operation SHALL discard all outstanding entries without issuing data_ok; memory contents SHALL NOT be reset, and writes already accepted SHALL persist.

Structure
REQ-029 Default parameter values and the entry record type (wr, rdata, age) SHALL reside in shared package sram_like_pkg.
REQ-030 The outstanding queue SHALL be a single sub-module sram_resp_fifo (synchronous, DEPTH entries, per-entry age tracking, empty/full/count outputs); memory array and accept logic SHALL stay in the top block.

Verification
REQ-031 Write addr=0x10, wdata=0xDEADBEEF, wstrb=4'hF, then read addr=0x10 -> two data_ok pulses in order; the read returns rdata=0xDEADBEEF, LATENCY=2 cycles after its accept.
REQ-032 Partial write wstrb=4'b0101, wdata=0x11223344 over 0xFFFFFFFF at addr 0x20, then read -> rdata=0xFF22FF44.
REQ-033 Six back-to-back reads with resp_hold=1 -> four accepts, addr_ok=0 while full; release hold -> six data_ok pulses on consecutive cycles, in accept order.
REQ-034 Read 0x30 (old value 0xA) followed next cycle by write 0xB to 0x30 -> read returns 0xA.
REQ-035 Assert reset with three entries outstanding -> no data_ok is issued afterward, count=0, and a subsequent read returns a pre-reset written value.
REQ-036 Continuous requests with resp_hold=0 -> after the first data_ok, one data_ok per cycle; count never exceeds LATENCY+1.

Source files
------------

// File: rtl/sram_like_pkg.sv
// sram_like_pkg: shared defaults and the outstanding-entry record for the SRAM-like responder.
package sram_like_pkg;
    localparam int AW_DEF = 16;
    localparam int DEPTH_DEF = 4;
    localparam int LATENCY_DEF = 2;
    localparam int AGE_W = 8;
    typedef struct packed {
        logic             wr;
        logic [1:0]       size;
        logic [31:0]      rdata;
        logic [AGE_W-1:0] age;
    } entry_t;
endpackage

// File: rtl/sram_resp_fifo.sv
// sram_resp_fifo: in-order queue of accepted transactions, each with a saturating age counter.
module sram_resp_fifo
    import sram_like_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int LATENCY = LATENCY_DEF,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        push_wr,
    input  logic [1:0]  push_size,
    input  logic [31:0] push_rdata,
    input  logic        pop,
    output entry_t      head,
    output logic        empty,
    output logic        full,
    output logic [PW:0] count
);
    localparam logic [AGE_W-1:0] LAT = AGE_W'(LATENCY);
    entry_t ent [DEPTH];
    logic [PW-1:0] wptr, rptr;
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) ent[i].age <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (ent[i].age != LAT) ent[i].age <= ent[i].age + 1'b1;
            // age 0 is the accept cycle itself, so the stored entry is already one cycle old
            if (push) begin
                ent[wptr] <= '{wr: push_wr, size: push_size, rdata: push_rdata, age: AGE_W'(1)};
                wptr <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end
    assign head = ent[rptr];
    assign empty = count == '0;
    assign full = count == (PW+1)'(DEPTH);
endmodule

// File: rtl/sram_like_responder.sv
// sram_like_responder: word memory with in-order, fixed-minimum-latency responses and test backpressure.
module sram_like_responder
    import sram_like_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    input  logic        resp_hold,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);
    localparam int PW = $clog2(DEPTH);
    logic [31:0] mem [2**AW];
    logic [AW-1:0] idx;
    entry_t head;
    logic empty, full;
    logic [PW:0] count;
    logic unused;
    assign idx = addr[AW+1:2];
    assign addr_ok = req && !full && !reset;
    assign data_ok = !reset && !empty && head.age == AGE_W'(LATENCY) && !resp_hold;
    assign rdata = data_ok && !head.wr ? head.rdata : 32'h0;
    assign unused = ^{count, head.size};
    // memory is never reset so accepted writes survive a reset
    always_ff @(posedge clk)
        if (addr_ok && wr)
            for (int b = 0; b < 4; b++)
                if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    sram_resp_fifo #(.DEPTH(DEPTH), .LATENCY(LATENCY)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(addr_ok),
        .push_wr(wr),
        .push_size(size),
        .push_rdata(mem[idx]),
        .pop(data_ok),
        .head(head),
        .empty(empty),
        .full(full),
        .count(count)
    );
endmodule

// File: tb/tb_sram_like_responder.sv
// tb_sram_like_responder: random and directed stimulus checked every cycle against a queue-based model.
module tb_sram_like_responder;
    localparam int AW = 8, DEPTH = 4, LAT = 2;
    logic clk = 0, reset, req, wr, resp_hold;
    logic [1:0] size;
    logic [31:0] addr, wdata, rdata;
    logic [3:0] wstrb;
    logic addr_ok, data_ok;
    int total = 0, bad = 0, cyc = 0;
    logic [31:0] mm [2**AW];
    typedef struct {logic wr; logic [31:0] d; int acc;} exp_t;
    exp_t q[$];
    int n_acc = 0, n_dok = 0, last_rd_cyc = 0;
    logic [31:0] last_rd = 0;
    int dok_cycles[$];

    sram_like_responder #(.AW(AW), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .addr(addr),
        .wstrb(wstrb), .wdata(wdata), .resp_hold(resp_hold),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    // model: a response is due once LAT cycles have passed since its accept cycle
    always @(negedge clk) begin : cmp
        logic e_ok, e_dok;
        logic [31:0] e_rd;
        logic [AW-1:0] ix;
        if (reset) begin
            chk("rst_addr_ok", {31'b0, addr_ok}, 0);
            chk("rst_data_ok", {31'b0, data_ok}, 0);
            chk("rst_rdata", rdata, 0);
            q.delete();
        end else begin
            e_ok = req && q.size() < DEPTH;
            e_dok = q.size() > 0 && !resp_hold && (cyc - q[0].acc >= LAT);
            e_rd = (e_dok && !q[0].wr) ? q[0].d : 32'h0;
            chk("addr_ok", {31'b0, addr_ok}, {31'b0, e_ok});
            chk("data_ok", {31'b0, data_ok}, {31'b0, e_dok});
            chk("rdata", rdata, e_rd);
            if (e_dok) begin
                n_dok++;
                dok_cycles.push_back(cyc);
                if (!q[0].wr) begin
                    last_rd = q[0].d;
                    last_rd_cyc = cyc;
                end
                void'(q.pop_front());
            end
            if (e_ok) begin
                ix = addr[AW+1:2];
                q.push_back('{wr: wr, d: mm[ix], acc: cyc});
                if (wr)
                    for (int b = 0; b < 4; b++)
                        if (wstrb[b]) mm[ix][8*b +: 8] = wdata[8*b +: 8];
                n_acc++;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, input logic h);
        req = r; wr = w; addr = a; wstrb = s; wdata = d; resp_hold = h;
        size = 2'($urandom_range(0, 3));
    endtask

    task automatic idle;
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic send(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input logic h, output int acc);
        int n = 0;
        logic got = 0;
        acc = 0;
        drive(1, w, a, s, d, h);
        do begin
            @(negedge clk);
            got = addr_ok;
            acc = cyc;
            tick();
            n++;
        end while (!got && n < 50);
        chk("send_accept", {31'b0, got}, 1);
    endtask

    task automatic drain;
        int n = 0;
        idle();
        while (q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk("drain", q.size(), 0);
    endtask

    initial begin
        int acc, acc0, k0, a0, d0;
        reset = 1;
        idle();
        repeat (3) tick();
        reset = 0;
        for (int i = 0; i < 2**AW; i++) send(1, i << 2, 4'hF, $urandom, 0, acc);
        drain();
        // write then read back
        send(1, 32'h10, 4'hF, 32'hDEADBEEF, 0, acc);
        send(0, 32'h10, 4'h0, 0, 0, acc);
        drain();
        chk("wr_rd_data", last_rd, 32'hDEADBEEF);
        chk("wr_rd_latency", last_rd_cyc - acc, LAT);
        // partial write
        send(1, 32'h20, 4'hF, 32'hFFFFFFFF, 0, acc);
        send(1, 32'h20, 4'b0101, 32'h11223344, 0, acc);
        send(0, 32'h20, 4'h0, 0, 0, acc);
        drain();
        chk("partial_wr", last_rd, 32'hFF22FF44);
        // read captures old data before a following write
        send(1, 32'h30, 4'hF, 32'hA, 0, acc);
        drain();
        send(0, 32'h30, 4'h0, 0, 0, acc);
        send(1, 32'h30, 4'hF, 32'hB, 0, acc);
        drain();
        chk("rd_before_wr", last_rd, 32'hA);
        // fill under backpressure, then release
        a0 = n_acc;
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, $urandom, 0, 0, 1);
            tick();
        end
        chk("full_accepts", n_acc - a0, 4);
        begin
            int n = 0;
            resp_hold = 0;
            while (n_acc - a0 < 6 && n < 20) begin
                addr = $urandom;
                tick();
                n++;
            end
        end
        drain();
        k0 = dok_cycles.size();
        chk("release_consec", dok_cycles[k0-1] - dok_cycles[k0-6], 5);
        // reset with entries outstanding
        send(1, 32'h40, 4'hF, 32'h12345678, 0, acc);
        drain();
        for (int i = 0; i < 3; i++) send(0, $urandom, 0, 0, 1, acc);
        d0 = n_dok;
        idle();
        reset = 1;
        repeat (2) tick();
        reset = 0;
        repeat (6) tick();
        chk("no_dok_after_rst", n_dok - d0, 0);
        send(0, 32'h40, 4'h0, 0, 0, acc);
        drain();
        chk("mem_persists", last_rd, 32'h12345678);
        // continuous traffic throughput
        k0 = dok_cycles.size();
        for (int i = 0; i < 30; i++) begin
            send(1'($urandom), $urandom, 4'($urandom), $urandom, 0, acc);
            if (i == 0) acc0 = acc;
        end
        drain();
        chk("stream_count", dok_cycles.size() - k0, 30);
        chk("stream_first", dok_cycles[k0] - acc0, LAT);
        chk("stream_consec", dok_cycles[k0+29] - dok_cycles[k0], 29);
        // random traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom), $urandom, 4'($urandom), $urandom,
                  $urandom_range(0, 3) == 0);
            reset = $urandom_range(0, 63) == 0;
            tick();
        end
        reset = 0;
        drain();
        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
